// File: rtl/thresholding_loader_pkg.sv
// rtl/thresholding_loader_pkg.sv - state encoding shared by the threshold loader
package thresholding_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/thresholding_loader.sv
// rtl/thresholding_loader.sv - streams channel-major thresholds into the thresholding unit write port
module thresholding_loader
  import thresholding_loader_pkg::*;
#(
  parameter int N = 2,
  parameter int M = 8,
  parameter int C = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [M-1:0]              s_tdata,
  input  logic                      s_tvalid,
  output logic                      s_tready,
  output logic                      twe,
  output logic [$clog2(C)+N-1:0]    twa,
  output logic [M-1:0]              twd,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int C_BITS = (C < 2) ? 1 : $clog2(C);
  localparam int A_BITS = $clog2(C) + N;
  localparam logic [N-1:0]      IDX_LAST = N'((1 << N) - 2);
  localparam logic [C_BITS-1:0] CNL_LAST = C_BITS'(C - 1);

  state_e               state_q;
  logic [N-1:0]         idx_q, idx_d;
  logic [C_BITS-1:0]    cnl_q, cnl_d;
  logic signed [M-1:0]  prev_q;
  logic                 twe_q;
  logic [A_BITS-1:0]    twa_q;
  logic [M-1:0]         twd_q;
  logic                 err_q;
  logic [A_BITS-1:0]    addr;
  logic                 hs;
  logic                 idx_wrap;
  logic                 last_word;
  logic                 order_bad;

  // A start pulse takes priority over a word, so ready is withheld in that cycle.
  assign s_tready  = (state_q == ST_LOAD) && !start;
  assign hs        = s_tvalid && s_tready;
  assign idx_wrap  = (idx_q == IDX_LAST);
  assign last_word = idx_wrap && (cnl_q == CNL_LAST);
  assign order_bad = (idx_q != '0) && ($signed(s_tdata) <= prev_q);

  always_comb begin
    idx_d = idx_q + 1'b1;
    cnl_d = cnl_q;
    if (idx_wrap) begin
      idx_d = '0;
      cnl_d = cnl_q + 1'b1;
    end
  end

  generate
    if (C == 1) begin : g_single_channel
      assign addr = idx_q;
    end else begin : g_multi_channel
      assign addr = {cnl_q, idx_q};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnl_q   <= '0;
      prev_q  <= '0;
      twe_q   <= 1'b0;
      twa_q   <= '0;
      twd_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      twe_q <= 1'b0;
      if (start) begin
        state_q <= ST_LOAD;
        idx_q   <= '0;
        cnl_q   <= '0;
        err_q   <= 1'b0;
      end else if (hs) begin
        // The offending word is still written; only the sticky flag records it.
        twe_q  <= 1'b1;
        twa_q  <= addr;
        twd_q  <= s_tdata;
        prev_q <= s_tdata;
        idx_q  <= idx_d;
        cnl_q  <= cnl_d;
        if (order_bad) err_q <= 1'b1;
        if (last_word) state_q <= ST_DONE;
      end
    end
  end

  assign twe  = twe_q;
  assign twa  = twa_q;
  assign twd  = twd_q;
  assign err  = err_q;
  assign busy = (state_q == ST_LOAD);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_thresholding_loader.sv
// tb/tb_thresholding_loader.sv - directed table-driven bench for thresholding_loader
module tb_thresholding_loader;

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] twa;
  } vec_t;

  typedef struct packed {
    int         cyc;
    logic [2:0] a;
    logic [7:0] d;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic [7:0] s_tdata = '0;
  logic       s_tvalid = 1'b0;

  logic       s_tready_a, twe_a, busy_a, done_a, err_a;
  logic [2:0] twa_a;
  logic [7:0] twd_a;
  logic       s_tready_b, twe_b, busy_b, done_b, err_b;
  logic [2:0] twa_b;
  logic [7:0] twd_b;

  int   n_vec = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   cur_sel = 1'b0;
  wr_t  log_a[$], log_b[$];
  int   hs_a[$], hs_b[$];
  vec_t exp_q[$];

  thresholding_loader #(.N(2), .M(8), .C(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tready(s_tready_a), .twe(twe_a), .twa(twa_a), .twd(twd_a),
    .busy(busy_a), .done(done_a), .err(err_a)
  );

  thresholding_loader #(.N(3), .M(8), .C(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tready(s_tready_b), .twe(twe_b), .twa(twa_b), .twd(twd_b),
    .busy(busy_b), .done(done_b), .err(err_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Handshakes and writes are logged mid-cycle so write latency can be checked per word.
  always @(negedge clk) begin
    if (s_tvalid && s_tready_a) hs_a.push_back(cyc);
    if (s_tvalid && s_tready_b) hs_b.push_back(cyc);
    if (twe_a) log_a.push_back('{cyc, twa_a, twd_a});
    if (twe_b) log_b.push_back('{cyc, twa_b, twd_b});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic clear_logs();
    log_a.delete(); log_b.delete(); hs_a.delete(); hs_b.delete();
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    #1;
    check("ready_low_on_start", sel ? s_tready_b : s_tready_a, 0);
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    #1;
  endtask

  task automatic send_one(input logic [7:0] d, input int gap);
    bit got;
    got = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    for (int k = 0; k < 20 && !got; k++) begin
      got = cur_sel ? s_tready_b : s_tready_a;
      tick();
    end
    if (!got) check("handshake_timeout", 0, 1);
    s_tvalid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic check_writes(input bit sel);
    wr_t lg[$];
    int  hq[$];
    int  n;
    tick();
    lg = sel ? log_b : log_a;
    hq = sel ? hs_b : hs_a;
    check("write_count", lg.size(), exp_q.size());
    n = (lg.size() < exp_q.size()) ? lg.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("twa[%0d]", i), int'(lg[i].a), int'(exp_q[i].twa));
      check($sformatf("twd[%0d]", i), int'(lg[i].d), int'(exp_q[i].data));
      if (i < hq.size()) check($sformatf("latency[%0d]", i), lg[i].cyc - hq[i], 1);
    end
    clear_logs();
    exp_q.delete();
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_s_tready"}, s_tready_a, 0);
    check({tag, "_twe"}, twe_a, 0);
    check({tag, "_twa"}, int'(twa_a), 0);
    check({tag, "_twd"}, int'(twd_a), 0);
    check({tag, "_busy"}, busy_a, 0);
    check({tag, "_done"}, done_a, 0);
    check({tag, "_err"}, err_a, 0);
  endtask

  initial begin
    vec_t t1[6];
    vec_t t3[3];
    vec_t t5[6];
    vec_t t6[6];
    vec_t t7[7];
    t1 = '{'{8'hF6, 3'd0}, '{8'h00, 3'd1}, '{8'h0A, 3'd2},
           '{8'hFB, 3'd4}, '{8'h05, 3'd5}, '{8'h14, 3'd6}};
    t3 = '{'{8'h05, 3'd0}, '{8'h05, 3'd1}, '{8'h07, 3'd2}};
    t5 = '{'{8'h0A, 3'd0}, '{8'h14, 3'd1}, '{8'h64, 3'd2},
           '{8'h9C, 3'd4}, '{8'h00, 3'd5}, '{8'h32, 3'd6}};
    t6 = '{'{8'h01, 3'd0}, '{8'h02, 3'd1}, '{8'h03, 3'd2},
           '{8'h04, 3'd4}, '{8'h05, 3'd5}, '{8'h06, 3'd6}};
    t7 = '{'{8'hFD, 3'd0}, '{8'hFE, 3'd1}, '{8'hFF, 3'd2}, '{8'h00, 3'd3},
           '{8'h01, 3'd4}, '{8'h02, 3'd5}, '{8'h03, 3'd6}};

    repeat (3) tick();
    check_reset_a("rst");
    check("rst_b_ready", s_tready_b, 0);
    check("rst_b_twe", twe_b, 0);
    check("rst_b_done", done_b, 0);
    rst_n = 1'b1;
    tick();

    // Continuous stream across both channels.
    pulse_start(1'b0);
    check("t1_busy", busy_a, 1);
    check("t1_ready", s_tready_a, 1);
    foreach (t1[i]) exp_q.push_back(t1[i]);
    foreach (t1[i]) send_one(t1[i].data, 0);
    check("t1_done_now", done_a, 1);
    check_writes(1'b0);
    check("t1_done", done_a, 1);
    check("t1_ready_off", s_tready_a, 0);
    check("t1_busy_off", busy_a, 0);
    check("t1_err", err_a, 0);

    // Gapped stream; done must appear right after the final handshake.
    pulse_start(1'b0);
    check("t2_done_cleared", done_a, 0);
    foreach (t1[i]) exp_q.push_back(t1[i]);
    foreach (t1[i]) begin
      send_one(t1[i].data, 0);
      check($sformatf("t2_done_after_%0d", i), done_a, (i == 5) ? 1 : 0);
      tick();
    end
    check_writes(1'b0);

    // Repeated value must set err while still being written.
    pulse_start(1'b0);
    foreach (t3[i]) exp_q.push_back(t3[i]);
    send_one(t3[0].data, 0);
    check("t3_err_w0", err_a, 0);
    send_one(t3[1].data, 0);
    check("t3_err_w1", err_a, 1);
    send_one(t3[2].data, 0);
    check("t3_err_w2", err_a, 1);
    check_writes(1'b0);
    pulse_start(1'b0);
    check("t3_err_cleared", err_a, 0);
    check("t3_busy_restart", busy_a, 1);

    // Descent across the channel boundary is legal.
    foreach (t5[i]) exp_q.push_back(t5[i]);
    foreach (t5[i]) send_one(t5[i].data, 0);
    check_writes(1'b0);
    check("t5_err", err_a, 0);
    check("t5_done", done_a, 1);

    // Reset in the middle of a load.
    pulse_start(1'b0);
    for (int i = 0; i < 3; i++) send_one(t1[i].data, 0);
    rst_n = 1'b0;
    tick();
    check_reset_a("midrst");
    rst_n = 1'b1;
    tick();
    clear_logs();
    pulse_start(1'b0);
    foreach (t6[i]) exp_q.push_back(t6[i]);
    foreach (t6[i]) send_one(t6[i].data, 0);
    check_writes(1'b0);
    check("t6_done", done_a, 1);
    check("t6_err", err_a, 0);

    // Single-channel instance: seven addresses, eighth word refused.
    cur_sel = 1'b1;
    pulse_start(1'b1);
    foreach (t7[i]) exp_q.push_back(t7[i]);
    foreach (t7[i]) send_one(t7[i].data, 0);
    check_writes(1'b1);
    check("t7_done", done_b, 1);
    check("t7_err", err_b, 0);
    s_tvalid = 1'b1;
    s_tdata  = 8'h7F;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("t7_extra_ready_%0d", k), s_tready_b, 0);
      tick();
    end
    s_tvalid = 1'b0;
    tick();
    check("t7_extra_writes", log_b.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
